scb_ctx_file: RTL and testbench

// - Multi-context successor to the single-word switch-control-bit (SCB) register file.
// - Holds NUM_CTX complete SCB words, each NODES x BLOCK_W bits.
// - Exactly one context is ACTIVE and drives the switch network.
// - Inactive contexts are loaded in BEAT_W slices over a valid/ready stream.
// - A loaded context becomes active only at a network-safe point (i_swap_ok), so reconfiguration is glitch-free.

---
 rtl/scb_ctx_file.sv | 140 ++++++++++++++
 tb/tb_scb_ctx_file.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scb_ctx_file.sv
// Multi-context switch-control-bit file: one active context drives the network while
// inactive contexts are streamed in; activation waits for a network-safe swap point.
module scb_ctx_file #(
  parameter int unsigned BLOCK_D        = 128,
  parameter int unsigned NUM_CTX        = 4,
  parameter int unsigned NODES_PER_BEAT = 8,
  localparam int unsigned BLOCK_W = $clog2(BLOCK_D),
  localparam int unsigned NODES   = BLOCK_D >> 1,
  localparam int unsigned DATA_W  = NODES * BLOCK_W,
  localparam int unsigned CTX_W   = $clog2(NUM_CTX),
  localparam int unsigned BEATS   = NODES / NODES_PER_BEAT,
  localparam int unsigned BEAT_W  = NODES_PER_BEAT * BLOCK_W,
  localparam int unsigned BIDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_load_start,
  input  logic [CTX_W-1:0]  i_load_ctx,
  input  logic              i_beat_valid,
  input  logic [BEAT_W-1:0] i_beat_data,
  output logic              o_beat_ready,
  output logic              o_load_done,
  output logic              o_load_err,
  input  logic              i_commit_req,
  input  logic [CTX_W-1:0]  i_commit_ctx,
  input  logic              i_swap_ok,
  output logic              o_commit_ack,
  output logic              o_commit_pend,
  output logic [CTX_W-1:0]  o_active_ctx,
  output logic [DATA_W-1:0] o_rd_data
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  localparam logic [BIDX_W-1:0] LastBeat = BIDX_W'(BEATS - 1);

  logic [DATA_W-1:0] r_ctx [NUM_CTX];
  state_e            r_state;
  logic [CTX_W-1:0]  r_ld_ctx;
  logic [BIDX_W-1:0] r_beat_idx;
  logic              r_beat_ready;
  logic              r_load_done;
  logic              r_load_err;
  logic              r_pend;
  logic [CTX_W-1:0]  r_pend_ctx;
  logic [CTX_W-1:0]  r_active;
  logic              r_ack;

  logic w_beat_fire;
  logic w_swap;

  assign w_beat_fire = i_beat_valid & r_beat_ready;
  // Never activate a context while it is still being written.
  assign w_swap = r_pend & i_swap_ok & ~((r_state != StIdle) & (r_ld_ctx == r_pend_ctx));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= StIdle;
      r_ld_ctx     <= '0;
      r_beat_idx   <= '0;
      r_beat_ready <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // Compared against the pre-swap active context when a swap lands this edge.
          if (i_load_start) begin
            if (i_load_ctx != r_active) begin
              r_ld_ctx     <= i_load_ctx;
              r_beat_idx   <= '0;
              r_beat_ready <= 1'b1;
              r_state      <= StLoad;
            end else begin
              r_load_err <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (w_beat_fire) begin
            r_beat_idx <= r_beat_idx + 1'b1;
            if (r_beat_idx == LastBeat) begin
              r_beat_ready <= 1'b0;
              r_load_done  <= 1'b1;
              r_state      <= StDone;
            end
          end
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned c = 0; c < NUM_CTX; c++) begin
        r_ctx[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CTX; c++) begin
        for (int unsigned b = 0; b < BEATS; b++) begin
          if (w_beat_fire && (r_ld_ctx == CTX_W'(c)) && (r_beat_idx == BIDX_W'(b))) begin
            r_ctx[c][b*BEAT_W +: BEAT_W] <= i_beat_data;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pend     <= 1'b0;
      r_pend_ctx <= '0;
      r_active   <= '0;
      r_ack      <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (w_swap) begin
        r_active <= r_pend_ctx;
        r_pend   <= 1'b0;
        r_ack    <= 1'b1;
      end else if (!r_pend && i_commit_req) begin
        r_pend     <= 1'b1;
        r_pend_ctx <= i_commit_ctx;
      end
    end
  end

  assign o_beat_ready  = r_beat_ready;
  assign o_load_done   = r_load_done;
  assign o_load_err    = r_load_err;
  assign o_commit_ack  = r_ack;
  assign o_commit_pend = r_pend;
  assign o_active_ctx  = r_active;
  assign o_rd_data     = r_ctx[r_active];

endmodule

// File: tb/tb_scb_ctx_file.sv
// Bench for scb_ctx_file: table of load/commit transactions plus hand-built corner sequences;
// expected active words are queued at commit request and checked when the ack appears.
module tb_scb_ctx_file;

  localparam int DATA_W = 448;
  localparam int BEAT_W = 56;
  localparam int NPB    = 8;
  localparam int BEATS  = 8;
  localparam int BW     = 7;

  logic              i_clk;
  logic              i_reset_n;
  logic              i_load_start;
  logic [1:0]        i_load_ctx;
  logic              i_beat_valid;
  logic [BEAT_W-1:0] i_beat_data;
  logic              o_beat_ready;
  logic              o_load_done;
  logic              o_load_err;
  logic              i_commit_req;
  logic [1:0]        i_commit_ctx;
  logic              i_swap_ok;
  logic              o_commit_ack;
  logic              o_commit_pend;
  logic [1:0]        o_active_ctx;
  logic [DATA_W-1:0] o_rd_data;

  scb_ctx_file #(
    .BLOCK_D       (128),
    .NUM_CTX       (4),
    .NODES_PER_BEAT(8)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_load_start (i_load_start),
    .i_load_ctx   (i_load_ctx),
    .i_beat_valid (i_beat_valid),
    .i_beat_data  (i_beat_data),
    .o_beat_ready (o_beat_ready),
    .o_load_done  (o_load_done),
    .o_load_err   (o_load_err),
    .i_commit_req (i_commit_req),
    .i_commit_ctx (i_commit_ctx),
    .i_swap_ok    (i_swap_ok),
    .o_commit_ack (o_commit_ack),
    .o_commit_pend(o_commit_pend),
    .o_active_ctx (o_active_ctx),
    .o_rd_data    (o_rd_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] mdl [4];
  logic [1:0]        act_mdl;
  logic [DATA_W-1:0] exp_q [$];
  logic [1:0]        exp_ctx_q [$];

  typedef struct {
    logic [1:0] ctx;
    logic [6:0] base;
    logic       exp_err;
    logic       commit;
    int         swap_wait;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [BEAT_W-1:0] pat(input logic [6:0] base, input int b);
    logic [BEAT_W-1:0] r;
    logic [6:0]        v;
    v = base + 7'(b);
    for (int n = 0; n < NPB; n++) r[n*BW +: BW] = v;
    return r;
  endfunction

  // Ack must be visible now (or within budget cycles); pops the scoreboard either way.
  task automatic wait_ack(input string name, input int budget);
    logic [DATA_W-1:0] e;
    logic [1:0]        ec;
    for (int k = 0; k < budget && o_commit_ack !== 1'b1; k++) step();
    e  = exp_q.pop_front();
    ec = exp_ctx_q.pop_front();
    if (o_commit_ack !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_ack: got %b want 1 within %0d cycles", name, o_commit_ack, budget);
    end else begin
      chk({name, "_rd"}, o_rd_data, e);
      chk({name, "_ctx"}, DATA_W'(o_active_ctx), DATA_W'(ec));
      act_mdl = ec;
    end
  endtask

  task automatic do_load(input logic [1:0] ctx, input logic [6:0] base, input logic exp_err);
    i_load_start = 1'b1;
    i_load_ctx   = ctx;
    step();
    i_load_start = 1'b0;
    if (exp_err) begin
      chk("err_pulse", DATA_W'(o_load_err), 1);
      chk("err_ready", DATA_W'(o_beat_ready), 0);
      step();
      chk("err_clear", DATA_W'(o_load_err), 0);
      chk("err_ready2", DATA_W'(o_beat_ready), 0);
      chk("err_store", o_rd_data, mdl[act_mdl]);
      return;
    end
    chk("start_noerr", DATA_W'(o_load_err), 0);
    chk("start_ready", DATA_W'(o_beat_ready), 1);
    for (int b = 0; b < BEATS; b++) begin
      i_beat_valid = 1'b1;
      i_beat_data  = pat(base, b);
      step();
      mdl[ctx][b*BEAT_W +: BEAT_W] = pat(base, b);
      if (b < BEATS - 1) chk("beat_nodone", DATA_W'(o_load_done), 0);
    end
    i_beat_valid = 1'b0;
    chk("load_done", DATA_W'(o_load_done), 1);
    chk("done_ready", DATA_W'(o_beat_ready), 0);
    chk("rd_unchanged", o_rd_data, mdl[act_mdl]);
    step();
    chk("done_end", DATA_W'(o_load_done), 0);
    // Beat offered while not ready must be dropped.
    i_beat_valid = 1'b1;
    i_beat_data  = '1;
    step();
    i_beat_valid = 1'b0;
  endtask

  task automatic do_commit(input string name, input logic [1:0] ctx, input int swait);
    i_commit_req = 1'b1;
    i_commit_ctx = ctx;
    i_swap_ok    = (swait == 0);
    exp_q.push_back(mdl[ctx]);
    exp_ctx_q.push_back(ctx);
    step();
    i_commit_req = 1'b0;
    chk({name, "_noack_early"}, DATA_W'(o_commit_ack), 0);
    chk({name, "_pend"}, DATA_W'(o_commit_pend), 1);
    for (int w = 0; w < swait; w++) begin
      i_swap_ok = 1'b0;
      step();
      chk({name, "_pend_hold"}, DATA_W'(o_commit_pend), 1);
      chk({name, "_act_hold"}, DATA_W'(o_active_ctx), DATA_W'(act_mdl));
    end
    i_swap_ok = 1'b1;
    step();
    wait_ack(name, 0);
    i_swap_ok = 1'b0;
    step();
    chk({name, "_ack_end"}, DATA_W'(o_commit_ack), 0);
    chk({name, "_pend_end"}, DATA_W'(o_commit_pend), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0] = '{ctx: 2'd1, base: 7'd0,   exp_err: 1'b0, commit: 1'b1, swap_wait: 0};
    vt[1] = '{ctx: 2'd1, base: 7'd5,   exp_err: 1'b1, commit: 1'b0, swap_wait: 0};
    vt[2] = '{ctx: 2'd3, base: 7'd40,  exp_err: 1'b0, commit: 1'b1, swap_wait: 3};
    vt[3] = '{ctx: 2'd0, base: 7'd100, exp_err: 1'b0, commit: 1'b1, swap_wait: 1};
    vt[4] = '{ctx: 2'd0, base: 7'd77,  exp_err: 1'b1, commit: 1'b0, swap_wait: 0};

    for (int c = 0; c < 4; c++) mdl[c] = '0;
    act_mdl      = 2'd0;
    i_reset_n    = 1'b0;
    i_load_start = 1'b0;
    i_load_ctx   = '0;
    i_beat_valid = 1'b0;
    i_beat_data  = '0;
    i_commit_req = 1'b0;
    i_commit_ctx = '0;
    i_swap_ok    = 1'b0;
    repeat (3) step();
    i_reset_n = 1'b1;
    step();
    chk("rst_rd", o_rd_data, '0);
    chk("rst_act", DATA_W'(o_active_ctx), 0);
    chk("rst_ready", DATA_W'(o_beat_ready), 0);
    chk("rst_pend", DATA_W'(o_commit_pend), 0);
    chk("rst_pulses", DATA_W'({o_load_done, o_load_err, o_commit_ack}), 0);

    for (int i = 0; i < 5; i++) begin
      do_load(vt[i].ctx, vt[i].base, vt[i].exp_err);
      if (vt[i].commit) do_commit("vec_commit", vt[i].ctx, vt[i].swap_wait);
    end

    // Commit of a context that is still loading: held until the load finishes.
    for (int b = 0; b < BEATS; b++) mdl[2][b*BEAT_W +: BEAT_W] = pat(7'd20, b);
    i_load_start = 1'b1;
    i_load_ctx   = 2'd2;
    step();
    i_load_start = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      i_beat_valid = 1'b1;
      i_beat_data  = pat(7'd20, b);
      if (b == 3) begin
        i_commit_req = 1'b1;
        i_commit_ctx = 2'd2;
        i_swap_ok    = 1'b1;
        exp_q.push_back(mdl[2]);
        exp_ctx_q.push_back(2'd2);
      end
      step();
      i_commit_req = 1'b0;
      if (b >= 3) begin
        chk("busy_pend", DATA_W'(o_commit_pend), 1);
        chk("busy_noack", DATA_W'(o_commit_ack), 0);
      end
    end
    i_beat_valid = 1'b0;
    chk("busy_done", DATA_W'(o_load_done), 1);
    chk("busy_act", DATA_W'(o_active_ctx), DATA_W'(act_mdl));
    step();
    chk("busy_idle_noack", DATA_W'(o_commit_ack), 0);
    chk("busy_idle_pend", DATA_W'(o_commit_pend), 1);
    step();
    wait_ack("busy_commit", 0);
    i_swap_ok = 1'b0;
    step();

    // Long pending commit; a second request is ignored.
    i_commit_req = 1'b1;
    i_commit_ctx = 2'd1;
    exp_q.push_back(mdl[1]);
    exp_ctx_q.push_back(2'd1);
    step();
    i_commit_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        i_commit_req = 1'b1;
        i_commit_ctx = 2'd3;
      end
      step();
      i_commit_req = 1'b0;
      chk("hold_pend", DATA_W'(o_commit_pend), 1);
      chk("hold_act", DATA_W'(o_active_ctx), DATA_W'(act_mdl));
    end
    i_swap_ok = 1'b1;
    step();
    wait_ack("hold_commit", 0);
    step();
    chk("hold_no_second_ack", DATA_W'(o_commit_ack), 0);
    chk("hold_no_second_pend", DATA_W'(o_commit_pend), 0);
    step();
    chk("hold_act_final", DATA_W'(o_active_ctx), 1);
    i_swap_ok = 1'b0;

    // Reset in the middle of a load with a commit pending.
    i_load_start = 1'b1;
    i_load_ctx   = 2'd2;
    step();
    i_load_start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      i_beat_valid = 1'b1;
      i_beat_data  = pat(7'd60, b);
      if (b == 1) begin
        i_commit_req = 1'b1;
        i_commit_ctx = 2'd2;
        i_swap_ok    = 1'b1;
      end
      step();
      i_commit_req = 1'b0;
    end
    chk("pre_rst_pend", DATA_W'(o_commit_pend), 1);
    i_beat_data = pat(7'd60, 4);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("arst_rd", o_rd_data, '0);
    chk("arst_act", DATA_W'(o_active_ctx), 0);
    chk("arst_pend", DATA_W'(o_commit_pend), 0);
    chk("arst_ready", DATA_W'(o_beat_ready), 0);
    chk("arst_pulses", DATA_W'({o_load_done, o_load_err, o_commit_ack}), 0);
    for (int c = 0; c < 4; c++) mdl[c] = '0;
    act_mdl = 2'd0;
    exp_q.delete();
    exp_ctx_q.delete();
    i_beat_valid = 1'b0;
    i_swap_ok    = 1'b0;
    step();
    step();
    i_reset_n = 1'b1;
    step();
    do_load(2'd1, 7'd9, 1'b0);
    do_commit("post_rst_commit", 2'd1, 0);
    do_commit("partial_cleared", 2'd2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
